// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable RAM family.
// be_expand works on a fixed maximum lane count; callers slice the low DW bits.
package ram_pkg;

    typedef enum logic [0:0] {ST_CLEAR, ST_READY} ram_st_e;

    localparam int BYTE_W = 8;
    localparam int MAX_BE = 32;

    function automatic logic [MAX_BE*BYTE_W-1:0] be_expand(input logic [MAX_BE-1:0] be);
        logic [MAX_BE*BYTE_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < MAX_BE; b++) begin
            mask[b*BYTE_W +: BYTE_W] = {BYTE_W{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One read port: captures the array word plus any same-edge write, merges per byte,
// and optionally adds a second register stage. Data holds between valid pulses.
module ram_rd_port #(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [DW-1:0] rd_word,
    input  logic [DW-1:0] fwd_mask,
    input  logic [DW-1:0] fwd_data,
    output logic [DW-1:0] r_data,
    output logic          r_valid
);

    logic [DW-1:0] word_q;
    logic [DW-1:0] mask_q;
    logic [DW-1:0] wdat_q;
    logic [DW-1:0] merged;
    logic          valid_q;

    // Write data is captured alongside the old word so a later write cannot disturb this read.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            mask_q  <= '0;
            wdat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_req;
            if (rd_req) begin
                word_q <= rd_word;
                mask_q <= fwd_mask;
                wdat_q <= fwd_data & fwd_mask;
            end
        end
    end

    assign merged = (word_q & ~mask_q) | wdat_q;

    generate
        if (RD_LAT == 2) begin : gen_lat2
            logic [DW-1:0] data_q2;
            logic          valid_q2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q2  <= '0;
                    valid_q2 <= 1'b0;
                end else begin
                    valid_q2 <= valid_q;
                    if (valid_q) begin
                        data_q2 <= merged;
                    end
                end
            end

            assign r_data  = data_q2;
            assign r_valid = valid_q2;
        end else begin : gen_lat1
            assign r_data  = merged;
            assign r_valid = valid_q;
        end
    endgenerate

endmodule

// File: rtl/ram_2p_be_bypass.sv
// 1-write / NRD-read synchronous RAM with byte enables, write-first forwarding,
// 1- or 2-cycle read latency and an optional clear sweep after reset.
module ram_2p_be_bypass
    import ram_pkg::*;
#(
    parameter int            DW         = 32,
    parameter int            AW         = 12,
    parameter int            MEM_NUM    = 4096,
    parameter int            NRD        = 2,
    parameter int            RD_LAT     = 1,
    parameter int            CLR_ON_RST = 1,
    parameter logic [DW-1:0] CLR_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en_i,
    input  logic [AW-1:0]        w_addr_i,
    input  logic [DW-1:0]        w_data_i,
    input  logic [DW/BYTE_W-1:0] w_be_i,
    input  logic [NRD-1:0]       r_en_i,
    input  logic [NRD*AW-1:0]    r_addr_i,
    output logic [NRD*DW-1:0]    r_data_o,
    output logic [NRD-1:0]       r_valid_o,
    output logic                 init_busy_o
);

    localparam int          NB        = DW / BYTE_W;
    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_NUM);
    localparam logic [AW-1:0] LAST_PTR = AW'(MEM_NUM - 1);

    ram_st_e       state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic [DW-1:0] mem [MEM_NUM];

    logic                      ready;
    logic                      w_fire;
    logic [MAX_BE-1:0]         be_wide;
    logic [MAX_BE*BYTE_W-1:0]  mask_wide;
    logic                      mask_unused;
    logic [DW-1:0]             w_mask;

    assign ready       = (state == ST_READY);
    assign init_busy_o = (state == ST_CLEAR);
    assign w_fire      = ready && w_en_i && ({1'b0, w_addr_i} < MEM_LIMIT);

    assign be_wide     = MAX_BE'(w_be_i);
    assign mask_wide   = be_expand(be_wide);
    assign w_mask      = mask_wide[DW-1:0];
    assign mask_unused = ^mask_wide;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == ST_CLEAR) begin
            ptr_nxt = ptr + AW'(1);
            if (ptr == LAST_PTR) begin
                state_nxt = ST_READY;
                ptr_nxt   = '0;
            end
        end
    end

    // The sweep owns the write port while it runs; user writes only touch enabled lanes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= CLR_VAL;
            end else if (w_fire) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_be_i[b]) begin
                        mem[w_addr_i][b*BYTE_W +: BYTE_W] <= w_data_i[b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : gen_rd
            logic [AW-1:0] rd_addr;
            logic          rd_in_range;
            logic [DW-1:0] rd_word;
            logic [DW-1:0] fwd_mask;

            assign rd_addr     = r_addr_i[p*AW +: AW];
            assign rd_in_range = ({1'b0, rd_addr} < MEM_LIMIT);
            assign rd_word     = rd_in_range ? mem[rd_addr] : '0;
            // Out-of-range writes never fire, so they can never forward into a read.
            assign fwd_mask    = (w_fire && (w_addr_i == rd_addr)) ? w_mask : '0;

            ram_rd_port #(
                .DW     (DW),
                .RD_LAT (RD_LAT)
            ) u_rd_port (
                .clk      (clk),
                .rst      (rst),
                .rd_req   (ready && r_en_i[p]),
                .rd_word  (rd_word),
                .fwd_mask (fwd_mask),
                .fwd_data (w_data_i),
                .r_data   (r_data_o[p*DW +: DW]),
                .r_valid  (r_valid_o[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_2p_be_bypass.sv
// Scoreboard bench: two instances (RD_LAT 1 and 2) share stimulus; per-port queues
// hold expected read data and monitors pop them on every valid pulse.
module tb_ram_2p_be_bypass;

    localparam int            MEM_NUM = 12;
    localparam logic [31:0]   CLR     = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    logic [1:0]  r_en;
    logic [7:0]  r_addr;
    logic [63:0] da, db;
    logic [1:0]  va, vb;
    logic        busy_a, busy_b;

    logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];
    int          errors = 0;
    int          checks = 0;
    int          ca, cb;
    logic [31:0] pat [4];

    ram_2p_be_bypass #(
        .DW(32), .AW(4), .MEM_NUM(MEM_NUM), .NRD(2), .RD_LAT(1),
        .CLR_ON_RST(1), .CLR_VAL(CLR)
    ) dut_a (
        .clk(clk), .rst(rst), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_be_i(w_be), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(da),
        .r_valid_o(va), .init_busy_o(busy_a)
    );

    ram_2p_be_bypass #(
        .DW(32), .AW(4), .MEM_NUM(MEM_NUM), .NRD(2), .RD_LAT(2),
        .CLR_ON_RST(1), .CLR_VAL(CLR)
    ) dut_b (
        .clk(clk), .rst(rst), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_be_i(w_be), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(db),
        .r_valid_o(vb), .init_busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got valid pulse expected none", name);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the responses expected from it.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input logic [1:0] re,
                                 input logic [3:0] ra0, input logic [3:0] ra1,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [1:0] push);
        @(negedge clk);
        w_en   = we;
        w_addr = wa;
        w_data = wd;
        w_be   = be;
        r_en   = re;
        r_addr = {ra1, ra0};
        if (push[0]) begin
            if (re[0]) qa0.push_back(e0);
            if (re[1]) qa1.push_back(e1);
        end
        if (push[1]) begin
            if (re[0]) qb0.push_back(e0);
            if (re[1]) qb1.push_back(e1);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic readBoth(input logic [3:0] ra0, input logic [3:0] ra1,
                            input logic [31:0] e0, input logic [31:0] e1);
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, ra0, ra1, e0, e1, 2'b11);
    endtask

    task automatic writeWord(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        applyStimulus(1'b1, wa, wd, be, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic measureSweep(output int na, output int nb);
        na = -1;
        nb = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (na < 0 && !busy_a) na = n;
            if (nb < 0 && !busy_b) nb = n;
            if (na >= 0 && nb >= 0) break;
        end
    endtask

    task automatic checkResetState();
        checkOutput("busy A in reset", 32'(busy_a), 32'd1);
        checkOutput("busy B in reset", 32'(busy_b), 32'd1);
        checkOutput("valid A in reset", 32'(va), 32'd0);
        checkOutput("valid B in reset", 32'(vb), 32'd0);
        checkOutput("data A p0 in reset", da[31:0], 32'd0);
        checkOutput("data A p1 in reset", da[63:32], 32'd0);
        checkOutput("data B p0 in reset", db[31:0], 32'd0);
        checkOutput("data B p1 in reset", db[63:32], 32'd0);
    endtask

    // Every valid pulse must match the oldest outstanding expectation for that port.
    always @(negedge clk) begin
        if (va[0]) begin
            if (qa0.size() == 0) flagUnexpected("A.p0");
            else checkOutput("A.p0 data", da[31:0], qa0.pop_front());
        end
        if (va[1]) begin
            if (qa1.size() == 0) flagUnexpected("A.p1");
            else checkOutput("A.p1 data", da[63:32], qa1.pop_front());
        end
        if (vb[0]) begin
            if (qb0.size() == 0) flagUnexpected("B.p0");
            else checkOutput("B.p0 data", db[31:0], qb0.pop_front());
        end
        if (vb[1]) begin
            if (qb1.size() == 0) flagUnexpected("B.p1");
            else checkOutput("B.p1 data", db[63:32], qb1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        pat[0] = 32'h0A0A0A0A;
        pat[1] = 32'h1B1B1B1B;
        pat[2] = 32'h2C2C2C2C;
        pat[3] = 32'h3D3D3D3D;
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0; r_en = '0; r_addr = '0;

        // Reset state and the initial clear sweep.
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;
        measureSweep(ca, cb);
        checkOutput("sweep A cycles", 32'(ca), 32'(MEM_NUM));
        checkOutput("sweep B cycles", 32'(cb), 32'(MEM_NUM));

        // Every word holds the clear value; back-to-back reads on both ports.
        for (int a = 0; a < MEM_NUM; a++) begin
            readBoth(4'(a), 4'(MEM_NUM - 1 - a), CLR, CLR);
        end

        // Byte enables.
        writeWord(4'd5, 32'h11223344, 4'b1111);
        writeWord(4'd5, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b01, 4'd5, 4'd0, 32'h11BB33DD, 32'd0, 2'b11);

        // Same-edge forwarding, then a following write that must not disturb it.
        writeWord(4'd7, 32'h00000000, 4'b1111);
        applyStimulus(1'b1, 4'd7, 32'hCAFEF00D, 4'b1100, 2'b11, 4'd7, 4'd7,
                      32'hCAFE0000, 32'hCAFE0000, 2'b11);
        writeWord(4'd7, 32'h12345678, 4'b1111);
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b01, 4'd7, 4'd0, 32'h12345678, 32'd0, 2'b11);

        // Pipelined reads in order, then latency of a single request.
        for (int i = 0; i < 4; i++) writeWord(4'(i), pat[i], 4'b1111);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b10, 4'd0, 4'(i), 32'd0, pat[i], 2'b11);
        end
        idleCycles(4);
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b01, 4'd2, 4'd0, pat[2], 32'd0, 2'b11);
        idleCycles(1);
        checkOutput("A valid at +1", 32'(va[0]), 32'd1);
        checkOutput("B valid at +1", 32'(vb[0]), 32'd0);
        idleCycles(1);
        checkOutput("A valid at +2", 32'(va[0]), 32'd0);
        checkOutput("B valid at +2", 32'(vb[0]), 32'd1);

        // Out-of-range accesses and an all-zero byte enable.
        writeWord(4'd1, 32'h01010101, 4'b1111);
        writeWord(4'd13, 32'hFFFFFFFF, 4'b1111);
        writeWord(4'd12, 32'hEEEEEEEE, 4'b1111);
        writeWord(4'd2, 32'hFFFFFFFF, 4'b0000);
        applyStimulus(1'b1, 4'd13, 32'h55555555, 4'b1111, 2'b11, 4'd13, 4'd13,
                      32'd0, 32'd0, 2'b11);
        readBoth(4'd2, 4'd12, pat[2], 32'd0);
        readBoth(4'd0, 4'd13, pat[0], 32'd0);
        readBoth(4'd1, 4'd13, 32'h01010101, 32'd0);
        idleCycles(4);
        checkOutput("A p0 hold", da[31:0], 32'h01010101);
        checkOutput("B p0 hold", db[31:0], 32'h01010101);
        checkOutput("A p1 hold", da[63:32], 32'd0);
        checkOutput("B p1 hold", db[63:32], 32'd0);

        // Reset with reads in flight: only the RD_LAT=1 result escapes before reset lands.
        applyStimulus(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'd4, 4'd4, CLR, CLR, 2'b01);
        idleCycles(1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState();

        // Reset mid-sweep with requests held active; all must be ignored while busy.
        rst = 1'b0; w_en = 1'b1; w_addr = 4'd0; w_data = 32'd0; w_be = 4'b1111;
        r_en = 2'b11; r_addr = {4'd5, 4'd0};
        repeat (5) @(negedge clk);
        checkOutput("busy A mid-sweep", 32'(busy_a), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        measureSweep(ca, cb);
        checkOutput("restart sweep A cycles", 32'(ca), 32'(MEM_NUM));
        checkOutput("restart sweep B cycles", 32'(cb), 32'(MEM_NUM));
        readBoth(4'd0, 4'd5, CLR, CLR);
        readBoth(4'd3, 4'd11, CLR, CLR);

        idleCycles(5);
        checkOutput("A p0 queue drained", 32'(qa0.size()), 32'd0);
        checkOutput("A p1 queue drained", 32'(qa1.size()), 32'd0);
        checkOutput("B p0 queue drained", 32'(qb0.size()), 32'd0);
        checkOutput("B p1 queue drained", 32'(qb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
